// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode constants and the queued {pc, inst} entry type.
// Optional feature macro used by the top: ID_BYPASS_EN.
package if_id_queue_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic                   RstEnable  = 1'b1;
  localparam logic                   ChipEnable = 1'b1;
  localparam logic [INST_ADDR_W-1:0] ZeroWord   = '0;
  localparam logic [INST_W-1:0]      NopInst    = 32'h0;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } if_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x 64-bit entry storage: synchronous write port, asynchronous read port.
// Contents are not reset; validity is tracked entirely by the top's pointers.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  if_entry_t     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output if_entry_t     rdata_o
);

  if_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction FIFO with full-stall request and flush.
// Define ID_BYPASS_EN to forward a fetch straight to decode while the queue is empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0]      inst_i,
  input  logic                   flush_i,
  input  logic                   id_ready_i,
  output logic                   id_valid_o,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  output logic                   fetch_stall_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      wr_en;
  logic      rd_adv;
  logic      byp_take;
  if_entry_t wr_entry;
  if_entry_t rd_entry;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A pop in the same cycle never frees a slot for this cycle's push.
  assign push = (ce_i == ChipEnable) && !full && !flush_i;

`ifdef ID_BYPASS_EN
  logic byp;
  assign byp        = push && empty;
  assign id_valid_o = !empty || byp;
  assign byp_take   = byp && id_ready_i;
  always_comb begin
    id_pc_o   = ZeroWord;
    id_inst_o = NopInst;
    if (!empty) begin
      id_pc_o   = rd_entry.pc;
      id_inst_o = rd_entry.inst;
    end else if (byp) begin
      id_pc_o   = pc_i;
      id_inst_o = inst_i;
    end
  end
`else
  assign id_valid_o = !empty;
  assign byp_take   = 1'b0;
  assign id_pc_o    = empty ? ZeroWord : rd_entry.pc;
  assign id_inst_o  = empty ? NopInst  : rd_entry.inst;
`endif

  assign pop = id_valid_o && id_ready_i && !flush_i;

  // A bypassed entry consumed in its fetch cycle never touches storage.
  assign wr_en  = push && !byp_take;
  assign rd_adv = pop && !byp_take;

  assign fetch_stall_o = full;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry.pc   = pc_i;
  assign wr_entry.inst = inst_i;

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en && (rst != RstEnable)),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Directed-vector bench for if_id_queue (DEPTH = 4); expectations are hand-derived.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        fetch_stall_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ce_i          (ce_i),
    .pc_i          (pc_i),
    .inst_i        (inst_i),
    .flush_i       (flush_i),
    .id_ready_i    (id_ready_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .fetch_stall_o (fetch_stall_o)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h3401_0011 : (32'hA500_0000 | pc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs shortly after an edge and let combinational outputs settle.
  task automatic drive(input logic r, input logic ce, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    rst        = r;
    ce_i       = ce;
    pc_i       = pc;
    inst_i     = inst_of(pc);
    id_ready_i = rdy;
    flush_i    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 32'(id_valid_o), 32'd0);
    chk({tag, ".pc"},    id_pc_o,         32'h0);
    chk({tag, ".inst"},  id_inst_o,       32'h0);
    chk({tag, ".stall"}, 32'(fetch_stall_o), 32'd0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic stall);
    chk({tag, ".valid"}, 32'(id_valid_o), 32'd1);
    chk({tag, ".pc"},    id_pc_o,         pc);
    chk({tag, ".inst"},  id_inst_o,       inst_of(pc));
    chk({tag, ".stall"}, 32'(fetch_stall_o), 32'(stall));
  endtask

  initial begin
    drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);

    // Reset held three cycles with fetch enabled.
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
      chk_empty("reset");
    end

    // Fill: four pushes, no decode.
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    chk_empty("rst_release");
    tick();
    drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b0);
    chk_head("first_push", 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
    chk_head("fill2", 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'hC, 1'b0, 1'b0);
    chk_head("fill3", 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    chk_head("full", 32'h0, 1'b1);
    tick();
    // Fifth push was blocked; pop while full with another fetch.
    drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0);
    chk_head("full_hold", 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_head("pop_from_full", 32'h4, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_head("idle3", 32'h4, 1'b0);

    // Drain: 0x10 must not appear after 0xC.
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_head("drain8", 32'h8, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_head("drainC", 32'hC, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_empty("drained");

    // Steady stream: 16 fetches with decode always ready.
    for (int k = 0; k <= 16; k++) begin
      drive(1'b0, (k < 16), 32'(4 * k), 1'b1, 1'b0);
`ifdef ID_BYPASS_EN
      if (k < 16) chk_head("stream", 32'(4 * k), 1'b0);
      else        chk_empty("stream_end");
`else
      if (k == 0) chk_empty("stream_start");
      else        chk_head("stream", 32'(4 * (k - 1)), 1'b0);
`endif
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_empty("stream_drained");

    // Flush with a concurrent push and pop.
    drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h44, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h48, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h4C, 1'b1, 1'b1);
    chk_head("pre_flush", 32'h40, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_empty("flushed");
    tick();
    drive(1'b0, 1'b1, 32'h50, 1'b0, 1'b0);
    chk_empty("flush_push_absent");
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_head("after_flush", 32'h50, 1'b0);

    // Reset mid-operation drops queued entries.
    drive(1'b1, 1'b1, 32'h54, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_empty("mid_reset");

`ifdef ID_BYPASS_EN
    drive(1'b0, 1'b1, 32'h20, 1'b1, 1'b0);
    chk_head("bypass", 32'h20, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_empty("bypass_consumed");
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage (PC register plus instruction ROM) and the decode stage. Each enabled fetch cycle captures the current PC and the ROM instruction word into a small FIFO. The decode stage pops entries with a valid/ready handshake. The block raises a fetch-stall request when the FIFO is full, and on flush it discards every queued entry.

## Interface
Parameters:
- DEPTH, 4, number of queued {pc, inst} entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  reset, synchronous, active-high (`RstEnable = 1'b1`); sampled only on posedge clk.
- ce_i  input  1  fetch chip enable from the PC register; `ChipEnable` marks a valid fetch this cycle.
- pc_i  input  `InstAddrBus`  address of the instruction fetched this cycle.
- inst_i  input  `InstBus`  ROM data for pc_i (combinational ROM, same cycle).
- flush_i  input  1  redirect/exception; discard all entries.
- id_ready_i  input  1  decode accepts the head entry this cycle.
- id_valid_o  output  1  head entry valid.
- id_pc_o  output  `InstAddrBus`  head entry PC.
- id_inst_o  output  `InstBus`  head entry instruction.
- fetch_stall_o  output  1  queue full; the PC register must hold pc.

## Operation
- Storage: DEPTH-entry circular buffer of {pc, inst}, with read pointer rd_ptr, write pointer wr_ptr and occupancy count. Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- push = (ce_i == `ChipEnable`) && (count != DEPTH) && !flush_i.
- pop = id_valid_o && id_ready_i && !flush_i.
- Push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr.
- count update: +1 on push only, −1 on pop only, unchanged when both or neither.
- Full (count == DEPTH): push is blocked even if a pop happens in the same cycle. The freed slot is usable the following cycle.
- Empty (count == 0): id_valid_o = 0, id_pc_o = `ZeroWord`, id_inst_o = `NopInst` (32'h0). Decode therefore sees a bubble.
- Non-empty: id_valid_o = 1, and id_pc_o/id_inst_o = mem[rd_ptr].
- fetch_stall_o = (count == DEPTH). It is combinational from registered count only, with no path from inputs.
- flush_i: the next state has count = 0 and rd_ptr = wr_ptr = 0. Any push or pop in the flush cycle is ignored. Outputs show empty from the next cycle.
- Priority: rst > flush_i > push/pop.
- id_ready_i while empty has no effect.

## Timing
- Reset: count, rd_ptr and wr_ptr are 0. id_valid_o = 0, id_pc_o = 0, id_inst_o = 0, fetch_stall_o = 0 from the first edge with rst high.
- Reset mid-operation: all entries are lost on that edge.
- Latency with the macro absent: a push at edge N is visible at the outputs after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- fetch_stall_o rises in the cycle after the push that fills the queue. It falls in the cycle after the first pop from full.
- Invariants:
  - 0 ≤ count ≤ DEPTH.
  - Entries leave in strict FIFO order.
  - No entry is duplicated or dropped except by flush/rst.

## Configuration
- ID_BYPASS_EN defined: when count == 0 and push is true, id_valid_o/id_pc_o/id_inst_o are driven combinationally from ce_i/pc_i/inst_i in the same cycle. If id_ready_i is also high, the entry is consumed and not written (count stays 0). Otherwise it is written normally.
- ID_BYPASS_EN undefined: the outputs come only from storage, with one cycle of minimum latency and no input-to-output combinational path.

## Structure
- Shared constants in defines.v: `InstAddrBus`, `InstBus`, `RstEnable`, `ChipEnable`, `ZeroWord`, `NopInst`.
- One sub-module, if_id_queue_mem: a DEPTH×64-bit register file with a synchronous write port and an asynchronous read port.
- Pointer/count logic, flush and bypass stay in the top module.

## Test plan
- Reset: hold rst = 1 for 3 cycles while ce_i = 1 -> all outputs 0, count 0. On rst release, pc_i = 0x0 with inst 0x3401_0011 pushes, and id_pc_o = 0 / id_inst_o = 0x3401_0011 in the next cycle (macro off).
- Fill: id_ready_i = 0 with 4 pushes of pc 0x0, 0x4, 0x8, 0xC -> fetch_stall_o = 1 after the 4th. A 5th push of pc 0x10 is ignored, and the head stays pc 0x0.
- Pop while full: full queue with id_ready_i = 1 for one cycle and ce_i = 1 (pc 0x10) -> pc 0x10 is not stored that cycle. The head becomes 0x4, and fetch_stall_o = 0 in the next cycle.
- Steady stream: ce_i = 1 and id_ready_i = 1 continuously, pc 0x0–0x3C -> 16 pops in order. count stays 1 (macro off) or 0 (macro on), and fetch_stall_o stays 0.
- Flush: 3 entries queued with flush_i = 1, ce_i = 1 and id_ready_i = 1 in the same cycle -> next cycle id_valid_o = 0 and id_inst_o = 0. The push that occurred in the flush cycle is absent.
- Bypass (ID_BYPASS_EN): empty queue with push pc 0x20 and id_ready_i = 1 -> id_pc_o = 0x20 in the same cycle, and count remains 0.
